// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions for the pipelined CLA adder and subtractor.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_HALF  = CLA_WIDTH / 2;

  // Result of one 16-bit lookahead slice. The group generate/propagate pair
  // lets a parent level chain slices without waiting on the ripple carry.
  typedef struct packed {
    logic [CLA_HALF-1:0] diff;
    logic                carry;
    logic                g;
    logic                p;
  } cla_slice_t;

endpackage

// File: rtl/pipelined_cla32bt_subtractor_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
interface pipelined_cla32bt_subtractor_if
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  // Producer/consumer side: drives operands and the result-ready.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );

endinterface

// File: rtl/cla16_block.sv
// Combinational 16-bit carry-lookahead slice: four 4-bit lookahead groups
// joined by a second lookahead level across the groups.
module cla16_block
  import cla_pkg::*;
(
  input  logic [CLA_HALF-1:0] x,
  input  logic [CLA_HALF-1:0] y,
  input  logic                cin,
  output cla_slice_t          res
);

  logic [CLA_HALF-1:0] g;
  logic [CLA_HALF-1:0] p;
  logic [CLA_HALF-1:0] c;
  logic [3:0]          gg;
  logic [3:0]          gp;
  logic [4:0]          gc;

  assign g = x & y;
  assign p = x ^ y;

  // Per-group generate/propagate and the carries inside each group.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;

    assign gp[k] = &p[B+:4];
    assign gg[k] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);

    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  // Group-level lookahead: every group carry-in straight from cin.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign res = '{
    diff:  p ^ c,
    carry: gc[4],
    g:     gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0]),
    p:     &gp
  };

endmodule

// File: rtl/pipelined_cla32bt_subtractor.sv
// Two-stage pipelined CLA subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin. Stage 1 resolves the low half, stage 2 the high half and flags.
// HALF must equal CLA_HALF, the width of the cla16_block slice.
module pipelined_cla32bt_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int HALF  = WIDTH / 2
) (
  input logic                           clk,
  input logic                           rst_n,
  pipelined_cla32bt_subtractor_if.slave bus
);

  logic       adv;
  logic       cin;
  cla_slice_t lo_res;
  cla_slice_t hi_res;

  // Stage 1 registers
  logic            s1_valid_q;
  logic [HALF-1:0] s1_lo_diff_q;
  logic            s1_lo_carry_q;
  logic [HALF-1:0] s1_a_hi_q;
  logic [HALF-1:0] s1_nb_hi_q;
  logic            s1_a_msb_q;
  logic            s1_b_msb_q;

  // Stage 2 (output) registers and their next values
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // The whole pipeline advances together; a held result freezes every stage.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign cin          = ~bus.bin;

  cla16_block u_lo (
    .x   (bus.a[HALF-1:0]),
    .y   (~bus.b[HALF-1:0]),
    .cin (cin),
    .res (lo_res)
  );

  cla16_block u_hi (
    .x   (s1_a_hi_q),
    .y   (s1_nb_hi_q),
    .cin (s1_lo_carry_q),
    .res (hi_res)
  );

  // Stage 2 result and flags from the high slice and the stored low half.
  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    diff_d = {hi_res.diff, s1_lo_diff_q};
    bout_d = ~hi_res.carry;
    ovf_d  = (s1_a_msb_q != s1_b_msb_q) && (hi_res.diff[HALF-1] != s1_a_msb_q);
    zero_d = (diff_d == '0);
  end

  // Stage 1: capture the low-half result and the high-half operands on accept.
  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lo_diff_q  <= '0;
      s1_lo_carry_q <= 1'b0;
      s1_a_hi_q     <= '0;
      s1_nb_hi_q    <= '0;
      s1_a_msb_q    <= 1'b0;
      s1_b_msb_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_lo_diff_q  <= lo_res.diff;
        s1_lo_carry_q <= lo_res.carry;
        s1_a_hi_q     <= bus.a[WIDTH-1:HALF];
        s1_nb_hi_q    <= ~bus.b[WIDTH-1:HALF];
        s1_a_msb_q    <= bus.a[WIDTH-1];
        s1_b_msb_q    <= bus.b[WIDTH-1];
      end
    end
  end

  // Stage 2: register the full result; bubbles leave the data registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // Each slice's ripple-style carry must agree with its own group generate/propagate.
  a_lo_gp : assert property (@(posedge clk) disable iff (!rst_n)
    lo_res.carry == (lo_res.g | (lo_res.p & cin)));
  a_hi_gp : assert property (@(posedge clk) disable iff (!rst_n)
    hi_res.carry == (hi_res.g | (hi_res.p & s1_lo_carry_q)));

endmodule
